// File: rtl/mfp_irq_ctrl.sv
// MFP68901 interrupt controller: 16 prioritised channels with enable, pending,
// in-service and mask registers, a registered IRQ and a two-state acknowledge FSM.
module mfp_irq_ctrl #(
  parameter logic [7:0] VR_RESET = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  REG_ADDR,
  input  logic        REG_WE,
  input  logic [7:0]  DAT_I,
  output logic [7:0]  DAT_O,
  input  logic [15:0] SRC_PULSE,
  input  logic        IACK,
  output logic        IRQ,
  output logic        VEC_VALID,
  output logic [7:0]  VEC,
  output logic        NO_ACK
);

  typedef enum logic {IDLE, RESP} ack_state_t;

  ack_state_t  state, state_n;
  logic [15:0] ier, ipr, isr, imr;
  logic [15:0] ier_n, ipr_n, isr_n, imr_n;
  logic [7:0]  vr, vr_n;
  logic        irq_q;
  logic        w_valid;
  logic [3:0]  w_idx;

  logic [15:0] svc_at_or_above;
  logic [15:0] elig;
  logic        any_elig;
  logic [3:0]  hi_idx;
  logic        ack_fire;

  // A channel is blocked when it or any higher channel is in service.
  always_comb begin
    svc_at_or_above[15] = isr[15];
    for (int n = 14; n >= 0; n--) begin
      svc_at_or_above[n] = svc_at_or_above[n+1] | isr[n];
    end
    elig     = ipr & imr & ~svc_at_or_above;
    any_elig = |elig;
    hi_idx   = 4'd0;
    for (int n = 0; n < 16; n++) begin
      if (elig[n]) hi_idx = 4'(n);
    end
  end

  // Update order: ack retire first, then register write, then event set (set wins).
  always_comb begin
    ier_n    = ier;
    ipr_n    = ipr;
    isr_n    = isr;
    imr_n    = imr;
    vr_n     = vr;
    ack_fire = (state == RESP) && w_valid;
    if (ack_fire) begin
      ipr_n[w_idx] = 1'b0;
      if (vr[3]) isr_n[w_idx] = 1'b1;
    end
    if (REG_WE) begin
      case (REG_ADDR)
        5'h03: begin
          ier_n[15:8] = DAT_I;
          ipr_n[15:8] = ipr_n[15:8] & DAT_I;
        end
        5'h04: begin
          ier_n[7:0] = DAT_I;
          ipr_n[7:0] = ipr_n[7:0] & DAT_I;
        end
        5'h05: ipr_n[15:8] = ipr_n[15:8] & DAT_I;
        5'h06: ipr_n[7:0]  = ipr_n[7:0] & DAT_I;
        5'h07: isr_n[15:8] = isr_n[15:8] & DAT_I;
        5'h08: isr_n[7:0]  = isr_n[7:0] & DAT_I;
        5'h09: imr_n[15:8] = DAT_I;
        5'h0A: imr_n[7:0]  = DAT_I;
        5'h0B: begin
          vr_n = DAT_I;
          if (!DAT_I[3]) isr_n = 16'h0000;
        end
        default: ;
      endcase
    end
    ipr_n = ipr_n | (SRC_PULSE & ier);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ier     <= 16'h0000;
      ipr     <= 16'h0000;
      isr     <= 16'h0000;
      imr     <= 16'h0000;
      vr      <= VR_RESET;
      irq_q   <= 1'b0;
      state   <= IDLE;
      w_valid <= 1'b0;
      w_idx   <= 4'd0;
    end else begin
      ier   <= ier_n;
      ipr   <= ipr_n;
      isr   <= isr_n;
      imr   <= imr_n;
      vr    <= vr_n;
      irq_q <= any_elig;
      state <= state_n;
      if (state == IDLE && IACK) begin
        w_valid <= any_elig;
        w_idx   <= hi_idx;
      end
    end
  end

  // Outputs are gated by RST so a reset during RESP suppresses the response.
  always_comb begin
    state_n   = state;
    VEC_VALID = 1'b0;
    NO_ACK    = 1'b0;
    VEC       = 8'h00;
    case (state)
      IDLE: if (IACK) state_n = RESP;
      RESP: begin
        state_n = IDLE;
        if (!RST) begin
          if (w_valid) begin
            VEC_VALID = 1'b1;
            VEC       = {vr[7:4], w_idx};
          end else begin
            NO_ACK = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign IRQ = irq_q;

  always_comb begin
    case (REG_ADDR)
      5'h03:   DAT_O = ier[15:8];
      5'h04:   DAT_O = ier[7:0];
      5'h05:   DAT_O = ipr[15:8];
      5'h06:   DAT_O = ipr[7:0];
      5'h07:   DAT_O = isr[15:8];
      5'h08:   DAT_O = isr[7:0];
      5'h09:   DAT_O = imr[15:8];
      5'h0A:   DAT_O = imr[7:0];
      5'h0B:   DAT_O = vr;
      default: DAT_O = 8'h00;
    endcase
  end

endmodule
